hollow_knightsoc_led_afterglow: RTL
===================================

// Module: hollow_knightsoc_led_afterglow
//
// PURPOSE
//   Downstream consumer of the LED PIO's 14-bit out_port. Turns each on/off LED bit into a
//   PWM-driven board LED with an "afterglow": an LED lights at full brightness immediately, then
//   fades linearly to off after software clears its bit. Gives health/soul indicators a smooth fade.
//   Sits between the PIO out_port and the top-level LEDR pins; single clock domain, no bus interface.
//
// PARAMETERS
//   N_LEDS    14      number of LED channels (matches PIO width)
//   BW        4       brightness bits per channel; MAX = 2**BW-1 (15)
//   PRESCALE  50000   clk cycles per decay tick (1 ms at 50 MHz); legal range >= 1
//
// PORTS
//   clk        in   1       system clock
//   reset_n    in   1       synchronous, active-low reset
//   led_in     in   N_LEDS  LED request bits from PIO out_port (same clk domain, no sync needed)
//   led_out    out  N_LEDS  PWM-modulated LED drive, registered
//   fading     out  1       registered; 1 when any channel has 0 < level < MAX and led_in bit low
//
// BEHAVIOUR
//   - Reset (reset_n=0 at a clk edge): led_out=0, fading=0, all level[i]=0, pwm_cnt=0, pre_cnt=0.
//     Reset mid-fade abandons the fade; no state survives.
//   - Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps; tick=1 in the cycle pre_cnt==PRESCALE-1.
//     PRESCALE=1 -> tick every cycle.
//   - PWM counter: pwm_cnt counts 0..MAX-1 and wraps (period MAX cycles), free-running.
//   - Per-channel level update, each clk edge, priority order:
//       1. led_in[i]=1            -> level[i] <= MAX (load wins over a simultaneous tick)
//       2. tick && level[i]!=0    -> level[i] <= level[i]-1
//       3. otherwise hold; level 0 never underflows.
//   - Output: led_out[i] <= (pwm_cnt < eff_level[i]), eff_level as defined under CONFIGURATION.
//     level MAX -> constantly 1; level 0 -> constantly 0; level k -> k high cycles per MAX-cycle period.
//   - Latency: led_in[i] rising at edge E -> level[i]=MAX after E -> led_out[i]=1 from edge E+1 on.
//     led_in falling: level holds MAX until the next tick, then decrements once per tick;
//     full fade from MAX to 0 takes MAX ticks (first decrement at <= PRESCALE cycles).
//   - Re-assert during fade: level snaps back to MAX on the next edge; no fade restart delay.
//   - fading <= OR over i of (!led_in[i] && level[i]!=0 && level[i]!=MAX), registered (1-cycle lag).
//   - All arithmetic unsigned; pwm_cnt and level are BW bits wide, pre_cnt is clog2(PRESCALE) bits
//     wide (min 1).
//
// CONFIGURATION
//   LED_GLOBAL_DIM_EN defined: adds input port  dim  in  BW  global brightness cap (from a second
//     PIO); eff_level[i] = min(level[i], dim). dim=0 forces led_out=0 but the fade state keeps
//     evolving. A dim change takes effect on the next edge.
//   Not defined: no dim port; eff_level[i] = level[i].
//
// TESTING  (N_LEDS=14, BW=4, PRESCALE=8 unless stated)
//   1. Hold reset_n=0 3 cycles with led_in=14'h3FFF -> led_out=0, fading=0 throughout and 1 cycle after release.
//   2. led_in=14'h0001 at edge E -> led_out[0]=1 from E+1 on, steady for 40 cycles; led_out[13:1]=0.
//   3. Then led_in=0 -> level 15,14,..,0 on successive ticks (8 cycles apart); at level 5 led_out[0]
//      high exactly 5 of 15 cycles; fading=1 until level 0, then 0; 15 ticks total.
//   4. Mid-fade (level 7) reassert led_in[0] in a tick cycle -> level=15 next edge (no decrement),
//      fading drops to 0 one cycle later.
//   5. PRESCALE=1, all 14 LEDs on then off -> all channels fade in lockstep, all at 0 after 15 cycles, no underflow.
//   6. LED_GLOBAL_DIM_EN, dim=3, led_in=14'h3FFF -> each led_out high 3 of 15 cycles; dim=0 -> all 0 next edge.

Source files
------------

// File: rtl/hollow_knightsoc_led_afterglow_if.sv
// LED afterglow signal bundle: PIO request bits in, PWM drive and fade flag out.
// The dim cap exists only when LED_GLOBAL_DIM_EN is defined.
interface hollow_knightsoc_led_afterglow_if #(
    parameter int N_LEDS = 14,
    parameter int BW     = 4
);
    logic [N_LEDS-1:0] led_in;
    logic [N_LEDS-1:0] led_out;
    logic              fading;
`ifdef LED_GLOBAL_DIM_EN
    logic [BW-1:0]     dim;
`endif

    modport master (
        output led_in,
`ifdef LED_GLOBAL_DIM_EN
        output dim,
`endif
        input  led_out,
        input  fading
    );

    modport slave (
        input  led_in,
`ifdef LED_GLOBAL_DIM_EN
        input  dim,
`endif
        output led_out,
        output fading
    );
endinterface

// File: rtl/hollow_knightsoc_led_afterglow.sv
// PWM LED driver with linear afterglow fade per channel.
// Optional LED_GLOBAL_DIM_EN adds a global brightness cap (dim).
module hollow_knightsoc_led_afterglow #(
    parameter int N_LEDS   = 14,
    parameter int BW       = 4,
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    hollow_knightsoc_led_afterglow_if.slave io_led
);
    localparam int MAX = (1 << BW) - 1;
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] LVL_MAX  = BW'(MAX);
    localparam logic [BW-1:0] PWM_LAST = BW'(MAX - 1);

    logic [PW-1:0]     r_pre_cnt;
    logic [BW-1:0]     r_pwm_cnt;
    logic [BW-1:0]     r_level [N_LEDS];
    logic [N_LEDS-1:0] r_led_out;
    logic              r_fading;

    logic              w_tick;
    logic [BW-1:0]     w_eff [N_LEDS];
    logic [N_LEDS-1:0] w_pwm;
    logic [N_LEDS-1:0] w_fade;

    assign w_tick = (r_pre_cnt == PRE_LAST);

    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
`ifdef LED_GLOBAL_DIM_EN
            w_eff[i] = (r_level[i] < io_led.dim) ? r_level[i] : io_led.dim;
`else
            w_eff[i] = r_level[i];
`endif
            w_pwm[i]  = (r_pwm_cnt < w_eff[i]);
            w_fade[i] = !io_led.led_in[i]
                      && (r_level[i] != '0)
                      && (r_level[i] != LVL_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
        end
    end

    // A request reload beats a coincident decay tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LEDS; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                if (io_led.led_in[i]) begin
                    r_level[i] <= LVL_MAX;
                end else if (w_tick && (r_level[i] != '0)) begin
                    r_level[i] <= r_level[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_led_out <= '0;
            r_fading  <= 1'b0;
        end else begin
            r_led_out <= w_pwm;
            r_fading  <= |w_fade;
        end
    end

    assign io_led.led_out = r_led_out;
    assign io_led.fading  = r_fading;
endmodule
